// File: rtl/id_ex_stage_if.sv
// ID-side bundle feeding the ID/EX stage: decoded instruction, branch flush,
// the forwarding taps from EX/MEM and MEM/WB, and the stall returned to the front end.
interface id_ex_stage_if #(
  parameter int N  = 32,
  parameter int RA = 5
);
  logic          id_valid;
  logic [N-1:0]  id_pc;
  logic [N-1:0]  id_rs1_data;
  logic [N-1:0]  id_rs2_data;
  logic [N-1:0]  id_imm;
  logic [RA-1:0] id_rs1;
  logic [RA-1:0] id_rs2;
  logic [RA-1:0] id_rd;
  logic [3:0]    id_alu_sel;
  logic          id_alu_src;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          flush;

  logic [RA-1:0] exmem_rd;
  logic          exmem_reg_write;
  logic [N-1:0]  exmem_result;
  logic [RA-1:0] memwb_rd;
  logic          memwb_reg_write;
  logic [N-1:0]  memwb_result;

  logic          stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_sel, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    input  stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_sel, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    output stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding into the ALU operands,
// load-use stall detection with bubble insertion, branch flush and a saturating stall counter.
module id_ex_stage #(
  parameter int N  = 32,
  parameter int RA = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [RA-1:0] ex_rd,
  output logic [N-1:0]  ex_pc,
  output logic [N-1:0]  ex_store_data,
  output logic [CW-1:0] stall_count
);

  logic [RA-1:0] ex_rs1;
  logic [RA-1:0] ex_rs2;
  logic [N-1:0]  ex_rs1_data;
  logic [N-1:0]  ex_rs2_data;
  logic [N-1:0]  ex_imm;
  logic [3:0]    ex_sel;
  logic          ex_alu_src;
  logic          load_use;
  logic          bubble;
  logic [N-1:0]  fwd_rs1;
  logic [N-1:0]  fwd_rs2;

  // rs2 is compared even for instructions that do not read it; a spurious stall is harmless.
  assign load_use = bus.id_valid & ~bus.flush & ex_valid & ex_mem_read &
                    (ex_rd != '0) &
                    ((ex_rd == bus.id_rs1) | (ex_rd == bus.id_rs2));
  assign bus.stall = load_use;
  assign bubble    = bus.flush | load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_sel       <= '0;
      ex_alu_src   <= 1'b0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_sel       <= '0;
      ex_alu_src   <= 1'b0;
    end else begin
      ex_valid     <= bus.id_valid;
      ex_reg_write <= bus.id_reg_write & bus.id_valid;
      ex_mem_read  <= bus.id_mem_read  & bus.id_valid;
      ex_mem_write <= bus.id_mem_write & bus.id_valid;
      ex_rd        <= bus.id_rd;
      ex_rs1       <= bus.id_rs1;
      ex_rs2       <= bus.id_rs2;
      ex_rs1_data  <= bus.id_rs1_data;
      ex_rs2_data  <= bus.id_rs2_data;
      ex_imm       <= bus.id_imm;
      ex_pc        <= bus.id_pc;
      ex_sel       <= bus.id_alu_sel;
      ex_alu_src   <= bus.id_alu_src;
    end
  end

  // The younger EX/MEM result wins over MEM/WB; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs1))
      fwd_rs1 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs1))
      fwd_rs1 = bus.memwb_result;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs2))
      fwd_rs2 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs2))
      fwd_rs2 = bus.memwb_result;
  end

  assign alu_a         = fwd_rs1;
  assign alu_b         = ex_alu_src ? ex_imm : fwd_rs2;
  assign alu_sel       = ex_sel;
  assign ex_store_data = fwd_rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_count <= '0;
    else if (load_use && (stall_count != {CW{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule
